// File: rtl/phy_rx.sv
// phy_rx: two-lane DisplayPort receive monitor for TPS1/TPS2 lock, error counting,
// inter-lane skew measurement and deskew delay lines.
module phy_rx (
    input  logic        dpclk,
    input  logic        reset,
    input  logic [15:0] rxdat0,
    input  logic [15:0] rxdat1,
    input  logic [1:0]  rxisk0,
    input  logic [1:0]  rxisk1,
    output logic [15:0] outdat0,
    output logic [15:0] outdat1,
    output logic [1:0]  outisk0,
    output logic [1:0]  outisk1,
    output logic [1:0]  cr_done,
    output logic [1:0]  eq_done,
    output logic        aligned,
    output logic [1:0]  deskew0,
    output logic [1:0]  deskew1,
    output logic [7:0]  errcnt0,
    output logic [7:0]  errcnt1
);
    typedef enum logic [1:0] {IDLE, CR, EQ} lane_st_t;

    lane_st_t    r_st    [2];
    logic [2:0]  r_ph    [2];
    logic [2:0]  r_t1run [2];
    logic [1:0]  r_bad   [2];
    logic [1:0]  r_per   [2];
    logic [1:0]  r_res   [2];
    logic [7:0]  r_err   [2];
    logic [1:0]  r_hunt, r_prevk, r_cr, r_eq;
    logic        r_meas, r_aligned;
    logic [2:0]  r_d;
    logic [1:0]  r_dsk   [2];
    logic [17:0] r_line  [2][2];
    logic [17:0] r_out   [2];

    logic [17:0] w_in    [2];
    logic [2:0]  w_nph   [2];
    logic [7:0]  w_sat   [2];
    logic [1:0]  w_t1, w_k, w_match, w_p0, w_lost, w_drop;
    logic        w_both, w_cap;
    logic [2:0]  w_capd;

    assign w_in[0] = {rxisk0, rxdat0};
    assign w_in[1] = {rxisk1, rxdat1};

    // w_nph is the TPS2 phase of the word arriving this cycle
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_t1[i]    = w_in[i] == {2'b00, 16'h4A4A};
            w_k[i]     = w_in[i] == {2'b01, 16'hCBBC};
            w_nph[i]   = r_ph[i] == 3'd4 ? 3'd0 : r_ph[i] + 3'd1;
            w_match[i] = w_nph[i] < 3'd2 ? w_k[i] : w_t1[i];
            w_sat[i]   = r_err[i] + {7'd0, r_err[i] != 8'hFF};
            w_p0[i]    = r_st[i] == EQ && w_nph[i] == 3'd0;
            w_lost[i]  = !w_match[i] && r_bad[i] == 2'd3;
            w_drop[i]  = r_st[i] == EQ && (w_lost[i] || (w_t1[i] && w_nph[i] < 3'd2 && r_res[i] == 2'd3));
        end
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            r_hunt  <= 2'b00;
            r_prevk <= 2'b00;
            r_cr    <= 2'b00;
            r_eq    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_st[i]    <= IDLE;
                r_ph[i]    <= 3'd0;
                r_t1run[i] <= 3'd0;
                r_bad[i]   <= 2'd0;
                r_per[i]   <= 2'd0;
                r_res[i]   <= 2'd0;
                r_err[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_prevk[i] <= w_k[i];
                if (r_st[i] == EQ) begin
                    r_ph[i]  <= w_nph[i];
                    r_bad[i] <= w_match[i] ? 2'd0 : r_bad[i] + 2'd1;
                    r_err[i] <= w_match[i] ? r_err[i] : w_sat[i];
                    if (w_nph[i] < 3'd2)
                        r_res[i] <= w_t1[i] ? r_res[i] + 2'd1 : 2'd0;
                    if (w_drop[i]) begin
                        r_st[i]    <= w_lost[i] ? IDLE : CR;
                        r_cr[i]    <= !w_lost[i];
                        r_eq[i]    <= 1'b0;
                        r_hunt[i]  <= 1'b0;
                        r_bad[i]   <= 2'd0;
                        r_res[i]   <= 2'd0;
                        r_t1run[i] <= 3'd0;
                    end
                end else begin
                    if (r_hunt[i]) begin
                        if (w_match[i]) begin
                            r_ph[i] <= w_nph[i];
                            if (w_nph[i] == 3'd4)
                                r_per[i] <= r_per[i] + 2'd1;
                            if (w_nph[i] == 3'd4 && r_per[i] == 2'd3) begin
                                r_st[i]   <= EQ;
                                r_cr[i]   <= 1'b1;
                                r_eq[i]   <= 1'b1;
                                r_hunt[i] <= 1'b0;
                                r_bad[i]  <= 2'd0;
                                r_res[i]  <= 2'd0;
                            end
                        end else begin
                            r_hunt[i]  <= 1'b0;
                            r_per[i]   <= 2'd0;
                            r_t1run[i] <= 3'd0;
                        end
                    // in CR a lone K is taken as phase 0; from IDLE it takes a K pair
                    end else if (w_k[i] && (r_prevk[i] || r_st[i] == CR)) begin
                        r_hunt[i] <= 1'b1;
                        r_ph[i]   <= r_st[i] == CR ? 3'd0 : 3'd1;
                        r_per[i]  <= 2'd0;
                    end else if (r_st[i] == IDLE) begin
                        r_t1run[i] <= w_t1[i] ? r_t1run[i] + 3'd1 : 3'd0;
                        if (w_t1[i] && r_t1run[i] == 3'd7) begin
                            r_st[i]  <= CR;
                            r_cr[i]  <= 1'b1;
                            r_bad[i] <= 2'd0;
                        end
                    end
                    if (r_st[i] == CR) begin
                        r_bad[i] <= w_t1[i] || w_k[i] ? 2'd0 : r_bad[i] + 2'd1;
                        r_err[i] <= w_t1[i] || w_k[i] ? r_err[i] : w_sat[i];
                        if (!w_t1[i] && !w_k[i] && r_bad[i] == 2'd3) begin
                            r_st[i]    <= IDLE;
                            r_cr[i]    <= 1'b0;
                            r_hunt[i]  <= 1'b0;
                            r_t1run[i] <= 3'd0;
                        end
                    end
                end
            end
        end
    end

    assign w_both = r_st[0] == EQ && r_st[1] == EQ;
    assign w_cap  = w_both && !r_aligned && !(|w_drop) && (r_meas ? w_p0[1] : w_p0[0] && w_p0[1]);
    assign w_capd = r_meas ? r_d : 3'd0;

    // d counts cycles from lane 0's phase-0 word to lane 1's
    always_ff @(posedge dpclk) begin
        if (reset) begin
            r_meas    <= 1'b0;
            r_aligned <= 1'b0;
            r_d       <= 3'd0;
            r_dsk[0]  <= 2'd0;
            r_dsk[1]  <= 2'd0;
        end else begin
            r_aligned <= w_cap || (r_aligned && !(|w_drop));
            r_meas    <= w_both && !r_aligned && !w_cap && (r_meas || w_p0[0]);
            r_d       <= r_meas ? r_d + 3'd1 : 3'd1;
            if (w_cap) begin
                r_dsk[0] <= w_capd <= 3'd2 ? w_capd[1:0] : 2'd0;
                r_dsk[1] <= w_capd <= 3'd2 ? 2'd0 : (w_capd == 3'd3 ? 2'd2 : 2'd1);
            end
        end
    end

    always_ff @(posedge dpclk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                r_line[i][0] <= 18'd0;
                r_line[i][1] <= 18'd0;
                r_out[i]     <= 18'd0;
            end else begin
                r_line[i][0] <= w_in[i];
                r_line[i][1] <= r_line[i][0];
                r_out[i]     <= r_dsk[i] == 2'd0 ? w_in[i] : (r_dsk[i] == 2'd1 ? r_line[i][0] : r_line[i][1]);
            end
        end
    end

    assign outdat0 = r_out[0][15:0];
    assign outisk0 = r_out[0][17:16];
    assign outdat1 = r_out[1][15:0];
    assign outisk1 = r_out[1][17:16];
    assign cr_done = r_cr;
    assign eq_done = r_eq;
    assign aligned = r_aligned;
    assign deskew0 = r_dsk[0];
    assign deskew1 = r_dsk[1];
    assign errcnt0 = r_err[0];
    assign errcnt1 = r_err[1];
endmodule
